// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution front end.
//   state_t  : sequencing states of the sliding-window controller
//   KERNEL   : window edge length (3x3 window)
//   out_dim  : output-map size along one axis for a given image size and stride
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int KERNEL = 3;

  function automatic int out_dim(input int img, input int stride);
    return (img - KERNEL) / stride + 1;
  endfunction

endpackage

// File: rtl/win_pos_counter.sv
// Raster position tracker for the pixel stream feeding the 3x3 datapath.
// Follows the row/column of the next pixel to be accepted, decides whether
// that pixel completes a window that is inside the image and on the stride
// grid, and keeps the matching output-map coordinates.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return all counters to the frame origin
//   advance    : a pixel is accepted this cycle
//   keep       : the pixel at the current position completes a kept window
//   last       : the current position is the final pixel of the frame
//   out_row    : output-map row of the window completed at this position
//   out_col    : output-map column of the window completed at this position
module win_pos_counter
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1,
  parameter int CW     = $clog2(IMG_W),
  parameter int RW     = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic          keep,
  output logic          last,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  // Phase = (position - 2) mod STRIDE once the position reaches the first
  // full window; zero before that.
  logic [PW-1:0] row_phase;
  logic [PW-1:0] col_phase;

  logic col_wrap;
  logic row_last;
  logic row_in;
  logic col_in;

  assign col_wrap = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign row_in   = (row >= RW'(KERNEL - 1));
  assign col_in   = (col >= CW'(KERNEL - 1));

  assign last = col_wrap && row_last;
  assign keep = row_in && col_in && (row_phase == '0) && (col_phase == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      row_phase <= '0;
      col_phase <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (clear) begin
      row       <= '0;
      col       <= '0;
      row_phase <= '0;
      col_phase <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col       <= '0;
        col_phase <= '0;
        out_col   <= '0;
        if (row_last) begin
          row       <= '0;
          row_phase <= '0;
          out_row   <= '0;
        end else begin
          row <= row + RW'(1);
          if (row_in) begin
            if (row_phase == PW'(STRIDE - 1)) begin
              row_phase <= '0;
              out_row   <= out_row + RW'(1);
            end else begin
              row_phase <= row_phase + PW'(1);
            end
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col_in) begin
          if (col_phase == PW'(STRIDE - 1)) begin
            col_phase <= '0;
            out_col   <= out_col + CW'(1);
          end else begin
            col_phase <= col_phase + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/sliding_window_ctrl.sv
// Flow-control wrapper that sequences a stall-less 3x3 window datapath over
// one IMG_W x IMG_H frame.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begins a frame (honoured only when idle)
//   pix_valid / pix_data / pix_ready : upstream pixel stream
//   sw_clear_n  : clears the datapath in the start cycle
//   sw_valid_in / sw_pixel : pixel forwarded to the datapath on acceptance
//   win_valid / win_ready  : window handshake toward the MAC array
//   win_row / win_col      : output-map coordinates of the presented window
//   busy        : a frame is in progress
//   frame_done  : one-cycle pulse once the last window has been consumed
module sliding_window_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = 1,
  parameter int CW         = $clog2(IMG_W),
  parameter int RW         = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  sw_clear_n,
  output logic                  sw_valid_in,
  output logic [DATA_WIDTH-1:0] sw_pixel,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  busy,
  output logic                  frame_done
);

  state_t        state;
  logic          start_frame;
  logic          keep;
  logic          last;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  assign start_frame = (state == IDLE) && start;

  // A new pixel is taken only when no window is outstanding or the
  // outstanding one is consumed in this same cycle; while a window waits,
  // valid_in stays low so the datapath's window registers hold still.
  assign pix_ready   = (state == RUN) && (!win_valid || win_ready);
  assign sw_valid_in = pix_valid && pix_ready;
  assign sw_pixel    = pix_data;
  assign sw_clear_n  = !start_frame;
  assign busy        = (state != IDLE);

  win_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .STRIDE (STRIDE),
    .CW     (CW),
    .RW     (RW)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_frame),
    .advance (sw_valid_in),
    .keep    (keep),
    .last    (last),
    .out_row (out_row),
    .out_col (out_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          win_valid <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (sw_valid_in) begin
            // The datapath shows the window one cycle after the pixel that
            // completes it, which is exactly when this register updates.
            win_valid <= keep;
            if (keep) begin
              win_row <= out_row;
              win_col <= out_col;
            end
            if (last) state <= DRAIN;
          end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!win_valid || win_ready) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sliding_window_ctrl.sv
module tb_sliding_window_ctrl;
  import conv_pkg::*;

  localparam int DW   = 8;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);
  localparam int NPIX = W * H;

  typedef struct {
    int r;
    int c;
  } rc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Index 0: STRIDE=1 instance, index 1: STRIDE=2 instance.
  logic          start_s     [2];
  logic          pix_valid_s [2];
  logic [DW-1:0] pix_data_s  [2];
  logic          win_ready_s [2];
  logic          pix_ready_s [2];
  logic          sw_clear_n_s[2];
  logic          sw_valid_s  [2];
  logic [DW-1:0] sw_pixel_s  [2];
  logic          win_valid_s [2];
  logic [RW-1:0] win_row_s   [2];
  logic [CW-1:0] win_col_s   [2];
  logic          busy_s      [2];
  logic          frame_done_s[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sliding_window_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .pix_valid(pix_valid_s[0]),
    .pix_data(pix_data_s[0]), .pix_ready(pix_ready_s[0]), .sw_clear_n(sw_clear_n_s[0]),
    .sw_valid_in(sw_valid_s[0]), .sw_pixel(sw_pixel_s[0]), .win_valid(win_valid_s[0]),
    .win_ready(win_ready_s[0]), .win_row(win_row_s[0]), .win_col(win_col_s[0]),
    .busy(busy_s[0]), .frame_done(frame_done_s[0])
  );

  sliding_window_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .pix_valid(pix_valid_s[1]),
    .pix_data(pix_data_s[1]), .pix_ready(pix_ready_s[1]), .sw_clear_n(sw_clear_n_s[1]),
    .sw_valid_in(sw_valid_s[1]), .sw_pixel(sw_pixel_s[1]), .win_valid(win_valid_s[1]),
    .win_ready(win_ready_s[1]), .win_row(win_row_s[1]), .win_col(win_col_s[1]),
    .busy(busy_s[1]), .frame_done(frame_done_s[1])
  );

  // A window completed by pixel (r,c) is kept when it lies inside the image
  // and its top-left corner sits on the stride grid.
  function automatic bit keep_px(input int r, input int c, input int s);
    return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
  endfunction

  task automatic check_idle_outputs(input int sel, input string tag);
    total++;
    if (win_valid_s[sel] !== 1'b0 || busy_s[sel] !== 1'b0 || pix_ready_s[sel] !== 1'b0 ||
        frame_done_s[sel] !== 1'b0 || win_row_s[sel] !== '0 || win_col_s[sel] !== '0 ||
        sw_clear_n_s[sel] !== 1'b1) begin
      bad++;
      $display("FAIL %s[%0d]: wv=%b busy=%b pr=%b fd=%b row=%0d col=%0d clr_n=%b, want 0 0 0 0 0 0 1",
               tag, sel, win_valid_s[sel], busy_s[sel], pix_ready_s[sel], frame_done_s[sel],
               win_row_s[sel], win_col_s[sel], sw_clear_n_s[sel]);
    end
  endtask

  // Runs one frame on instance sel. valid_pct/ready_pct set the random duty
  // of pix_valid and win_ready; hold_first stalls the first window 5 cycles;
  // inject pulses start mid-RUN and in DRAIN; stop_after>0 abandons the frame
  // after that many accepted pixels.
  task automatic run_frame(input int sel, input int valid_pct, input int ready_pct,
                           input bit hold_first, input bit inject, input int stop_after);
    int  s = (sel != 0) ? 2 : 1;
    rc_t exp_q[$];
    rc_t e;
    int  idx = 0, hs = 0, last_acc = -1, last_hs = -1, hold_left = 0, exp_fd = 0;
    bit  held = 0, inj_a = 0, inj_b = 0, done = 0, fd_seen = 0;
    bit  exp_wv = 0, acc = 0, hsk = 0, exp_pr = 0, stall = 0;
    logic [RW-1:0] prev_r = '0;
    logic [CW-1:0] prev_c = '0;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (keep_px(r, c, s)) begin
          e.r = (r - 2) / s;
          e.c = (c - 2) / s;
          exp_q.push_back(e);
        end

    @(posedge clk); #1;
    start_s[sel] = 1'b1; pix_valid_s[sel] = 1'b0; win_ready_s[sel] = 1'b0;
    @(negedge clk);
    total++;
    if (sw_clear_n_s[sel] !== 1'b0 || busy_s[sel] !== 1'b0 || frame_done_s[sel] !== 1'b0 ||
        win_valid_s[sel] !== 1'b0) begin
      bad++;
      $display("FAIL start_cycle[%0d]: clr_n=%b busy=%b fd=%b wv=%b, want 0 0 0 0",
               sel, sw_clear_n_s[sel], busy_s[sel], frame_done_s[sel], win_valid_s[sel]);
    end
    @(posedge clk); #1;
    start_s[sel] = 1'b0;

    for (int k = 0; k < 20000 && !done; k++) begin
      pix_valid_s[sel] = (idx < NPIX) && ($urandom_range(99) < valid_pct);
      pix_data_s[sel]  = DW'(idx);
      if (hold_first && !held && win_valid_s[sel]) begin
        held = 1; hold_left = 5;
      end
      if (hold_left > 0) begin
        win_ready_s[sel] = 1'b0; hold_left--;
      end else begin
        win_ready_s[sel] = ($urandom_range(99) < ready_pct);
      end
      start_s[sel] = 1'b0;
      if (inject && idx == 100 && !inj_a) begin start_s[sel] = 1'b1; inj_a = 1; end
      else if (inject && idx == NPIX && !inj_b) begin start_s[sel] = 1'b1; inj_b = 1; end

      @(negedge clk);
      exp_pr = (idx < NPIX) && (!exp_wv || win_ready_s[sel]);
      acc    = pix_valid_s[sel] && exp_pr;
      hsk    = exp_wv && win_ready_s[sel];

      total++;
      if (pix_ready_s[sel] !== exp_pr) begin
        bad++;
        $display("FAIL pix_ready[%0d] px=%0d: got %b want %b", sel, idx, pix_ready_s[sel], exp_pr);
      end
      total++;
      if (sw_valid_s[sel] !== acc || (acc && sw_pixel_s[sel] !== DW'(idx))) begin
        bad++;
        $display("FAIL forward[%0d] px=%0d: got v=%b d=%0d want v=%b d=%0d",
                 sel, idx, sw_valid_s[sel], sw_pixel_s[sel], acc, DW'(idx));
      end
      total++;
      if (win_valid_s[sel] !== exp_wv) begin
        bad++;
        $display("FAIL win_valid[%0d] px=%0d: got %b want %b", sel, idx, win_valid_s[sel], exp_wv);
      end
      total++;
      if (sw_clear_n_s[sel] !== 1'b1) begin
        bad++;
        $display("FAIL clear_busy[%0d]: sw_clear_n got %b want 1", sel, sw_clear_n_s[sel]);
      end
      if (stall) begin
        total++;
        if (win_row_s[sel] !== prev_r || win_col_s[sel] !== prev_c) begin
          bad++;
          $display("FAIL hold[%0d]: got (%0d,%0d) want (%0d,%0d)",
                   sel, win_row_s[sel], win_col_s[sel], prev_r, prev_c);
        end
      end
      if (hsk) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_window[%0d]: got (%0d,%0d) want none", sel, win_row_s[sel], win_col_s[sel]);
        end else begin
          e = exp_q.pop_front();
          if (win_row_s[sel] !== RW'(e.r) || win_col_s[sel] !== CW'(e.c)) begin
            bad++;
            $display("FAIL window[%0d] #%0d: got (%0d,%0d) want (%0d,%0d)",
                     sel, hs, win_row_s[sel], win_col_s[sel], e.r, e.c);
          end
        end
        hs++;
        last_hs = cyc;
      end
      total++;
      if (frame_done_s[sel]) begin
        exp_fd = (last_acc + 2 > last_hs + 1) ? last_acc + 2 : last_hs + 1;
        if (idx != NPIX || cyc != exp_fd || busy_s[sel] !== 1'b0) begin
          bad++;
          $display("FAIL frame_done[%0d]: got cycle %0d px=%0d busy=%b want cycle %0d px=%0d busy=0",
                   sel, cyc, idx, busy_s[sel], exp_fd, NPIX);
        end
        fd_seen = 1;
        done    = 1;
      end else if (busy_s[sel] !== 1'b1) begin
        bad++;
        $display("FAIL busy[%0d]: got %b want 1", sel, busy_s[sel]);
      end

      stall  = exp_wv && !win_ready_s[sel];
      prev_r = win_row_s[sel];
      prev_c = win_col_s[sel];
      if (acc) begin
        exp_wv   = keep_px(idx / W, idx % W, s);
        idx++;
        last_acc = cyc;
      end else if (hsk) begin
        exp_wv = 1'b0;
      end
      if (stop_after > 0 && idx == stop_after) done = 1;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    pix_valid_s[sel] = 1'b0;
    win_ready_s[sel] = 1'b0;
    start_s[sel]     = 1'b0;

    if (stop_after == 0) begin
      total++;
      if (!fd_seen) begin
        bad++;
        $display("FAIL timeout[%0d]: frame_done not seen, got %0d pixels want %0d", sel, idx, NPIX);
      end
      total++;
      if (hs != out_dim(H, s) * out_dim(W, s) || exp_q.size() != 0) begin
        bad++;
        $display("FAIL window_count[%0d]: got %0d (left %0d) want %0d",
                 sel, hs, exp_q.size(), out_dim(H, s) * out_dim(W, s));
      end
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_stride1();
    run_frame(0, 100, 100, 1'b0, 1'b0, 0);
  endtask

  task automatic test_stride2();
    run_frame(1, 100, 100, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_frame(0, 100, 100, 1'b1, 1'b0, 0);
  endtask

  task automatic test_bursty();
    run_frame(0, 50, 50, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_midframe();
    run_frame(0, 100, 100, 1'b0, 1'b0, 300);
    @(posedge clk); #1;
    // Pixel 299 (row 10, col 19) completes a kept window.
    total++;
    if (win_valid_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_window: win_valid got %b want 1", win_valid_s[0]);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs(0, "reset_midframe");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 70, 80, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 100, 100, 1'b0, 1'b1, 0);
    run_frame(0, 100, 100, 1'b0, 1'b0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; pix_valid_s[i] = 1'b0; pix_data_s[i] = '0; win_ready_s[i] = 1'b0;
    end
    test_reset();
    test_ramp_stride1();
    test_stride2();
    test_backpressure();
    test_bursty();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
